// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among several
// byte-stream requesters. A granted requester keeps the transmitter for a
// whole burst (until it marks a byte "last") or until it stalls in LOAD for
// LOCK_TIMEOUT cycles. Each accepted byte is handed to the transmitter with a
// one-cycle tx_start strobe, and the arbiter then waits for tx_done_tick.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int LOCK_TIMEOUT = 1024,
  localparam int GRANT_W     = $clog2(NUM_REQ),
  localparam int TIMER_W     = $clog2(LOCK_TIMEOUT)
) (
  input  logic                          clk,
  input  logic                          reset_in,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          tx_start,
  output logic [DATA_WIDTH-1:0]         tx_data,
  input  logic                          tx_done_tick,
  output logic [GRANT_W-1:0]            grant_id,
  output logic                          busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  // Pointer to the most recent grantee whose lock ended; the search for the
  // next grantee starts just above it so that grantee drops to lowest priority.
  logic [GRANT_W-1:0]    last_grant;
  logic [TIMER_W-1:0]    timeout_cnt;
  logic                  last_flag;

  // Round-robin search results
  logic [GRANT_W-1:0]    rr_sel;
  logic                  rr_found;
  logic [GRANT_W:0]      rr_cand;

  // Granted requester's byte and last marker
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  sel_last;

  // FSM control strobes
  logic                  grant_load;
  logic                  handshake;
  logic                  timer_clear;
  logic                  timer_inc;
  logic                  release_lock;

  // Search upward from last_grant+1 with wrap for the first valid requester.
  always_comb begin
    rr_found = 1'b0;
    rr_sel   = '0;
    rr_cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      rr_cand = {1'b0, last_grant} + (GRANT_W+1)'(k);
      if (rr_cand >= (GRANT_W+1)'(NUM_REQ)) begin
        rr_cand = rr_cand - (GRANT_W+1)'(NUM_REQ);
      end
      if (!rr_found && req_valid[rr_cand[GRANT_W-1:0]]) begin
        rr_found = 1'b1;
        rr_sel   = rr_cand[GRANT_W-1:0];
      end
    end
  end

  // Select the granted requester's byte and last marker.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == GRANT_W'(i)) begin
        sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    sel_last = req_last[grant_id];
  end

  // Ready goes only to the grantee, and only while LOAD is waiting for a byte.
  always_comb begin
    req_ready = '0;
    if (state == LOAD) begin
      req_ready[grant_id] = req_valid[grant_id];
    end
  end

  // Next-state logic and control strobes for the arbitration FSM.
  always_comb begin
    state_next   = state;
    grant_load   = 1'b0;
    handshake    = 1'b0;
    timer_clear  = 1'b0;
    timer_inc    = 1'b0;
    release_lock = 1'b0;
    case (state)
      IDLE: begin
        if (rr_found) begin
          grant_load  = 1'b1;
          timer_clear = 1'b1;
          state_next  = LOAD;
        end
      end
      LOAD: begin
        if (req_valid[grant_id]) begin
          handshake  = 1'b1;
          state_next = WAIT;
        end else if (timeout_cnt == TIMER_W'(LOCK_TIMEOUT - 1)) begin
          release_lock = 1'b1;
          state_next   = IDLE;
        end else begin
          timer_inc = 1'b1;
        end
      end
      WAIT: begin
        // A done tick during the tx_start cycle belongs to an earlier byte.
        if (tx_done_tick && !tx_start) begin
          if (last_flag) begin
            release_lock = 1'b1;
            state_next   = IDLE;
          end else begin
            timer_clear = 1'b1;
            state_next  = LOAD;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Current grantee and round-robin pointer bookkeeping.
  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      grant_id   <= '0;
      last_grant <= GRANT_W'(NUM_REQ - 1);
    end else begin
      if (grant_load) begin
        grant_id <= rr_sel;
      end
      if (release_lock) begin
        last_grant <= grant_id;
      end
    end
  end

  // Lock timer counting consecutive LOAD cycles without a handshake.
  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      timeout_cnt <= '0;
    end else if (timer_clear) begin
      timeout_cnt <= '0;
    end else if (timer_inc) begin
      timeout_cnt <= timeout_cnt + TIMER_W'(1);
    end
  end

  // Capture the accepted byte and fire the one-cycle start strobe.
  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      tx_start  <= 1'b0;
      tx_data   <= '0;
      last_flag <= 1'b0;
    end else begin
      tx_start <= handshake;
      if (handshake) begin
        tx_data   <= sel_data;
        last_flag <= sel_last;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed testbench for uart_tx_arbiter: a behavioural transmitter answers
// every tx_start with a done tick, and each scenario task checks its own
// hand-computed expectations.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ      = 4;
  localparam int DATA_WIDTH   = 8;
  localparam int LOCK_TIMEOUT = 8;

  logic                          clk;
  logic                          reset_in;
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          tx_start;
  logic [DATA_WIDTH-1:0]         tx_data;
  logic                          tx_done_tick;
  logic [1:0]                    grant_id;
  logic                          busy;

  int tests_run    = 0;
  int tests_failed = 0;

  // Transmitter model controls and capture log
  int  tx_delay    = 3;
  bit  tx_model_en = 1'b1;
  logic [7:0] sent_data  [$];
  logic [1:0] sent_grant [$];

  // Protocol monitor counters
  int start_cnt   = 0;
  int done_cnt    = 0;
  int overlap_cnt = 0;
  int multi_ready = 0;
  bit outstanding = 1'b0;

  // Requester byte sources used by the traffic runner
  logic [7:0] src_data [NUM_REQ][8];
  logic       src_last [NUM_REQ][8];
  int         src_len  [NUM_REQ];
  int         src_ptr  [NUM_REQ];

  uart_tx_arbiter #(
    .NUM_REQ      (NUM_REQ),
    .DATA_WIDTH   (DATA_WIDTH),
    .LOCK_TIMEOUT (LOCK_TIMEOUT)
  ) dut (
    .clk          (clk),
    .reset_in     (reset_in),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .tx_done_tick (tx_done_tick),
    .grant_id     (grant_id),
    .busy         (busy)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transmitter model: logs each started byte and pulses done tx_delay cycles later.
  always begin
    @(posedge clk);
    #1;
    if (tx_model_en && reset_in === 1'b1 && tx_start === 1'b1) begin
      sent_data.push_back(tx_data);
      sent_grant.push_back(grant_id);
      repeat (tx_delay) @(posedge clk);
      #1 tx_done_tick = 1'b1;
      @(posedge clk);
      #1 tx_done_tick = 1'b0;
    end
  end

  // Protocol monitor sampled on the falling edge.
  always @(negedge clk) begin
    if (reset_in !== 1'b1) begin
      outstanding = 1'b0;
    end else begin
      if (tx_done_tick === 1'b1) begin
        done_cnt++;
        outstanding = 1'b0;
      end
      if (tx_start === 1'b1) begin
        if (outstanding) overlap_cnt++;
        outstanding = 1'b1;
        start_cnt++;
      end
    end
    if ($countones(req_ready) > 1) multi_ready++;
  end

  // Watchdog against a hung run.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_valid = '0;
    req_last  = '0;
    reset_in  = 1'b0;
    tick();
    tick();
    reset_in = 1'b1;
    tick();
  endtask

  task automatic clear_sources();
    for (int i = 0; i < NUM_REQ; i++) begin
      src_len[i] = 0;
      src_ptr[i] = 0;
    end
    sent_data.delete();
    sent_grant.delete();
  endtask

  // Drives the source tables until every byte is accepted and the arbiter idles.
  task automatic run_traffic(input int max_cycles, output bit timed_out);
    bit all_done;
    timed_out = 1'b1;
    for (int c = 0; c < max_cycles; c++) begin
      all_done = 1'b1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (src_ptr[i] < src_len[i]) begin
          req_valid[i] = 1'b1;
          req_data[i*DATA_WIDTH +: DATA_WIDTH] = src_data[i][src_ptr[i]];
          req_last[i] = src_last[i][src_ptr[i]];
          all_done = 1'b0;
        end else begin
          req_valid[i] = 1'b0;
          req_last[i]  = 1'b0;
        end
      end
      if (all_done && busy === 1'b0) begin
        timed_out = 1'b0;
        break;
      end
      @(negedge clk);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_ready[i] === 1'b1 && req_valid[i]) src_ptr[i]++;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    int bad_busy  = 0;
    int bad_start = 0;
    int bad_ready = 0;
    reset_in     = 1'b0;
    req_valid    = '0;
    req_data     = '0;
    req_last     = '0;
    tx_done_tick = 1'b0;
    repeat (3) tick();
    tests_run++;
    if (busy !== 1'b0 || tx_start !== 1'b0 || req_ready !== 4'b0000) begin
      tests_failed++;
      $display("[TB] FAIL reset_ctrl: busy=%b tx_start=%b req_ready=%b, want 0 0 0000", busy, tx_start, req_ready);
    end
    tests_run++;
    if (tx_data !== 8'h00 || grant_id !== 2'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_regs: tx_data=%h grant_id=%0d, want 00 0", tx_data, grant_id);
    end
    reset_in = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (busy !== 1'b0) bad_busy++;
      if (tx_start !== 1'b0) bad_start++;
      if (req_ready !== 4'b0000) bad_ready++;
    end
    tests_run++;
    if (bad_busy != 0) begin
      tests_failed++;
      $display("[TB] FAIL idle_busy: %0d cycles busy, want 0", bad_busy);
    end
    tests_run++;
    if (bad_start != 0) begin
      tests_failed++;
      $display("[TB] FAIL idle_tx_start: %0d cycles tx_start, want 0", bad_start);
    end
    tests_run++;
    if (bad_ready != 0) begin
      tests_failed++;
      $display("[TB] FAIL idle_ready: %0d cycles ready, want 0", bad_ready);
    end
  endtask

  task automatic test_single_byte();
    int s0   = start_cnt;
    int fall = -1;
    tx_delay = 10;
    sent_data.delete();
    sent_grant.delete();
    req_valid = 4'b0100;
    req_data  = '0;
    req_data[23:16] = 8'hA5;
    req_last  = 4'b0100;
    tick();
    tests_run++;
    if (grant_id !== 2'd2 || busy !== 1'b1 || req_ready !== 4'b0100) begin
      tests_failed++;
      $display("[TB] FAIL single_grant: grant_id=%0d busy=%b req_ready=%b, want 2 1 0100", grant_id, busy, req_ready);
    end
    tick();
    tests_run++;
    if (tx_start !== 1'b1 || tx_data !== 8'hA5 || req_ready !== 4'b0000) begin
      tests_failed++;
      $display("[TB] FAIL single_start: tx_start=%b tx_data=%h req_ready=%b, want 1 a5 0000", tx_start, tx_data, req_ready);
    end
    req_valid = 4'b0000;
    req_last  = 4'b0000;
    tick();
    tests_run++;
    if (tx_start !== 1'b0 || busy !== 1'b1 || tx_data !== 8'hA5) begin
      tests_failed++;
      $display("[TB] FAIL single_wait: tx_start=%b busy=%b tx_data=%h, want 0 1 a5", tx_start, busy, tx_data);
    end
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (busy === 1'b0) begin
        fall = k;
        break;
      end
    end
    tests_run++;
    if (fall != 10) begin
      tests_failed++;
      $display("[TB] FAIL single_busy_fall: busy fell after %0d cycles, want 10", fall);
    end
    tests_run++;
    if (start_cnt - s0 != 1 || sent_data.size() != 1) begin
      tests_failed++;
      $display("[TB] FAIL single_count: %0d starts, %0d logged, want 1 1", start_cnt - s0, sent_data.size());
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_g [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [7:0] exp_d [5] = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC4};
    bit timed_out;
    int s0;
    int d0;
    do_reset();
    tx_delay = 3;
    clear_sources();
    s0 = start_cnt;
    d0 = done_cnt;
    src_data[0][0] = 8'hC0; src_last[0][0] = 1'b1;
    src_data[0][1] = 8'hC4; src_last[0][1] = 1'b1;
    src_data[1][0] = 8'hC1; src_last[1][0] = 1'b1;
    src_data[2][0] = 8'hC2; src_last[2][0] = 1'b1;
    src_data[3][0] = 8'hC3; src_last[3][0] = 1'b1;
    src_len[0] = 2; src_len[1] = 1; src_len[2] = 1; src_len[3] = 1;
    run_traffic(400, timed_out);
    tests_run++;
    if (timed_out) begin
      tests_failed++;
      $display("[TB] FAIL rr_timeout: traffic did not drain, %0d bytes sent, want 5", sent_data.size());
    end
    tests_run++;
    if (sent_data.size() != 5) begin
      tests_failed++;
      $display("[TB] FAIL rr_count: %0d bytes sent, want 5", sent_data.size());
    end
    for (int i = 0; i < 5 && i < sent_data.size(); i++) begin
      tests_run++;
      if (sent_grant[i] !== exp_g[i] || sent_data[i] !== exp_d[i]) begin
        tests_failed++;
        $display("[TB] FAIL rr_order[%0d]: grant=%0d data=%h, want %0d %h", i, sent_grant[i], sent_data[i], exp_g[i], exp_d[i]);
      end
    end
    tests_run++;
    if (start_cnt - s0 != 5 || done_cnt - d0 != 5) begin
      tests_failed++;
      $display("[TB] FAIL rr_start_per_done: starts=%0d dones=%0d, want 5 5", start_cnt - s0, done_cnt - d0);
    end
  endtask

  task automatic test_burst();
    logic [1:0] exp_g [4] = '{2'd1, 2'd1, 2'd1, 2'd0};
    logic [7:0] exp_d [4] = '{8'h11, 8'h22, 8'h33, 8'h0F};
    bit timed_out;
    tx_delay = 4;
    clear_sources();
    src_data[0][0] = 8'h0F; src_last[0][0] = 1'b1;
    src_data[1][0] = 8'h11; src_last[1][0] = 1'b0;
    src_data[1][1] = 8'h22; src_last[1][1] = 1'b0;
    src_data[1][2] = 8'h33; src_last[1][2] = 1'b1;
    src_len[0] = 1; src_len[1] = 3;
    run_traffic(400, timed_out);
    tests_run++;
    if (timed_out || sent_data.size() != 4) begin
      tests_failed++;
      $display("[TB] FAIL burst_count: timed_out=%b %0d bytes sent, want 0 4", timed_out, sent_data.size());
    end
    for (int i = 0; i < 4 && i < sent_data.size(); i++) begin
      tests_run++;
      if (sent_grant[i] !== exp_g[i] || sent_data[i] !== exp_d[i]) begin
        tests_failed++;
        $display("[TB] FAIL burst_order[%0d]: grant=%0d data=%h, want %0d %h", i, sent_grant[i], sent_data[i], exp_g[i], exp_d[i]);
      end
    end
  endtask

  task automatic test_lock_timeout();
    int stall_bad = 0;
    int fall      = -1;
    tx_delay  = 3;
    req_valid = 4'b1001;
    req_data  = '0;
    req_data[31:24] = 8'h3C;
    req_data[7:0]   = 8'h0F;
    req_last  = 4'b0001;
    tick();
    tests_run++;
    if (grant_id !== 2'd3 || req_ready !== 4'b1000) begin
      tests_failed++;
      $display("[TB] FAIL lock_grant: grant_id=%0d req_ready=%b, want 3 1000", grant_id, req_ready);
    end
    tick();
    tests_run++;
    if (tx_start !== 1'b1 || tx_data !== 8'h3C) begin
      tests_failed++;
      $display("[TB] FAIL lock_start: tx_start=%b tx_data=%h, want 1 3c", tx_start, tx_data);
    end
    req_valid = 4'b0001;
    repeat (4) tick();
    for (int c = 0; c < 8; c++) begin
      if (busy !== 1'b1 || grant_id !== 2'd3 || req_ready !== 4'b0000) stall_bad++;
      tick();
    end
    tests_run++;
    if (stall_bad != 0) begin
      tests_failed++;
      $display("[TB] FAIL lock_hold: %0d of 8 stall cycles wrong, want 0", stall_bad);
    end
    tests_run++;
    if (busy !== 1'b0 || grant_id !== 2'd3) begin
      tests_failed++;
      $display("[TB] FAIL lock_release: busy=%b grant_id=%0d, want 0 3", busy, grant_id);
    end
    tick();
    tests_run++;
    if (busy !== 1'b1 || grant_id !== 2'd0 || req_ready !== 4'b0001) begin
      tests_failed++;
      $display("[TB] FAIL lock_next_grant: busy=%b grant_id=%0d req_ready=%b, want 1 0 0001", busy, grant_id, req_ready);
    end
    tick();
    tests_run++;
    if (tx_start !== 1'b1 || tx_data !== 8'h0F) begin
      tests_failed++;
      $display("[TB] FAIL lock_next_start: tx_start=%b tx_data=%h, want 1 0f", tx_start, tx_data);
    end
    req_valid = 4'b0000;
    req_last  = 4'b0000;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (busy === 1'b0) begin
        fall = k;
        break;
      end
    end
    tests_run++;
    if (fall != 4) begin
      tests_failed++;
      $display("[TB] FAIL lock_drain: busy fell after %0d cycles, want 4", fall);
    end
  endtask

  task automatic test_reset_mid_transfer();
    int fall = -1;
    tx_model_en = 1'b0;
    req_valid = 4'b0100;
    req_data  = '0;
    req_data[23:16] = 8'h5A;
    req_last  = 4'b0100;
    tick();
    tick();
    tests_run++;
    if (tx_start !== 1'b1 || tx_data !== 8'h5A || grant_id !== 2'd2) begin
      tests_failed++;
      $display("[TB] FAIL rst_mid_start: tx_start=%b tx_data=%h grant_id=%0d, want 1 5a 2", tx_start, tx_data, grant_id);
    end
    req_valid = 4'b0000;
    req_last  = 4'b0000;
    tick();
    tests_run++;
    if (busy !== 1'b1 || tx_data !== 8'h5A) begin
      tests_failed++;
      $display("[TB] FAIL rst_mid_wait: busy=%b tx_data=%h, want 1 5a", busy, tx_data);
    end
    reset_in = 1'b0;
    #1;
    tests_run++;
    if (tx_data !== 8'h00 || busy !== 1'b0 || grant_id !== 2'd0 || tx_start !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL rst_mid_async: tx_data=%h busy=%b grant_id=%0d tx_start=%b, want 00 0 0 0", tx_data, busy, grant_id, tx_start);
    end
    tick();
    reset_in = 1'b1;
    tick();
    tx_done_tick = 1'b1;
    tick();
    tx_done_tick = 1'b0;
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL rst_stale_done: busy=%b, want 0", busy);
    end
    tx_model_en = 1'b1;
    tx_delay    = 3;
    req_valid   = 4'b0011;
    req_data    = '0;
    req_data[7:0]  = 8'h77;
    req_data[15:8] = 8'h88;
    req_last    = 4'b0011;
    tick();
    tests_run++;
    if (grant_id !== 2'd0 || req_ready !== 4'b0001) begin
      tests_failed++;
      $display("[TB] FAIL rst_first_grant: grant_id=%0d req_ready=%b, want 0 0001", grant_id, req_ready);
    end
    tick();
    tests_run++;
    if (tx_start !== 1'b1 || tx_data !== 8'h77) begin
      tests_failed++;
      $display("[TB] FAIL rst_first_start: tx_start=%b tx_data=%h, want 1 77", tx_start, tx_data);
    end
    req_valid = 4'b0000;
    req_last  = 4'b0000;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (busy === 1'b0) begin
        fall = k;
        break;
      end
    end
    tests_run++;
    if (fall != 4) begin
      tests_failed++;
      $display("[TB] FAIL rst_drain: busy fell after %0d cycles, want 4", fall);
    end
  endtask

  task automatic test_protocol_monitor();
    tests_run++;
    if (overlap_cnt != 0) begin
      tests_failed++;
      $display("[TB] FAIL start_before_done: %0d overlapping starts, want 0", overlap_cnt);
    end
    tests_run++;
    if (multi_ready != 0) begin
      tests_failed++;
      $display("[TB] FAIL ready_onehot: %0d cycles with several ready bits, want 0", multi_ready);
    end
  endtask

  // Scenario sequence.
  initial begin
    $display("[TB] uart_tx_arbiter bench starting");
    test_reset();
    test_single_byte();
    test_round_robin();
    test_burst();
    test_lock_timeout();
    test_reset_mid_transfer();
    test_protocol_monitor();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter among NUM_REQ byte-stream requesters.
- Grants the transmitter round-robin and drives the transmitter's start strobe and data byte.
- Waits for the transmitter's done tick before issuing the next byte.
- Supports multi-byte bursts: the granted requester keeps the transmitter until it marks a byte "last" or its lock times out.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_WIDTH, 8, byte width, equal to the transmitter data width
- LOCK_TIMEOUT, 1024, idle cycles a locked requester may stall mid-burst before its lock is released (>=2)

Ports:
- clk  input  1  system clock
- reset_in  input  1  asynchronous, active-low reset
- req_valid  input  NUM_REQ  per-requester byte available
- req_data  input  NUM_REQ*DATA_WIDTH  per-requester byte; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_last  input  NUM_REQ  byte ends the requester's burst; qualified by req_valid
- req_ready  output  NUM_REQ  byte accepted this cycle; combinational, at most one bit high
- tx_start  output  1  one-cycle start strobe to the transmitter
- tx_data  output  DATA_WIDTH  byte to transmit; stable from tx_start until the next accept
- tx_done_tick  input  1  transmitter finished its current byte (one-cycle pulse)
- grant_id  output  clog2(NUM_REQ)  index of the current or most recent grantee
- busy  output  1  high in every state except IDLE

Behaviour:
- Reset values (async, reset_in low):
  - state = IDLE
  - tx_start = 0, tx_data = 0, req_ready = 0, busy = 0
  - grant_id = 0
  - internal last-grant pointer = NUM_REQ-1, so requester 0 has first priority
  - timeout counter = 0, last-flag register = 0
- Reset mid-transfer abandons the burst immediately. A byte already started in the transmitter is not tracked; any tx_done_tick after reset is ignored while in IDLE.
- States: IDLE, LOAD, WAIT.
- IDLE:
  - If any req_valid bit is set, select the first set bit searching upward from (last_grant+1) mod NUM_REQ, with wrap.
  - Register the selection into grant_id, clear the timeout counter, go to LOAD on the next edge.
  - If no request, stay in IDLE. req_valid seen in cycle N gives grant_id updated and state LOAD in N+1.
- LOAD:
  - req_ready[grant_id] = req_valid[grant_id]; all other ready bits are 0.
  - On handshake:
    - register req_data[grant_id] into tx_data and req_last[grant_id] into the last-flag.
    - assert tx_start for exactly the next cycle.
    - go to WAIT.
  - No handshake: increment the timeout counter. When it reaches LOCK_TIMEOUT-1 without a handshake, set last_grant = grant_id and go to IDLE (lock released).
  - Other requesters are never served while LOAD holds a lock.
- WAIT:
  - Entered in the same cycle tx_start is high. A tx_done_tick in that cycle is ignored; it belongs to a previous byte.
  - On a later tx_done_tick:
    - If last-flag = 1: set last_grant = grant_id and go to IDLE.
    - Otherwise: clear the timeout counter and go to LOAD with the same grant.
  - WAIT has no timeout; the arbiter waits indefinitely for tx_done_tick.
- Throughput and latency:
  - Handshake in cycle N gives tx_start high in N+1.
  - tx_done_tick in cycle M gives a new accept no earlier than M+1 (burst) or M+2 (re-arbitration).
- Fairness: after a burst ends or times out, the same requester has lowest priority in the next arbitration.
- Simultaneous events:
  - req_valid changes in the IDLE decision cycle are sampled only in that cycle.
  - A grantee dropping req_valid in LOAD just stalls; it is not an error.
  - A single-byte transfer is a byte with req_last = 1.
- req_data and req_last of non-granted requesters are don't-care.

Test Plan:
- Reset release, req_valid=4'b0000 for 20 cycles -> busy=0, tx_start never high, req_ready=0.
- Only req 2 valid, data 8'hA5, last=1; done tick 10 cycles after tx_start -> grant_id=2 one cycle after request, req_ready[2] one cycle pulse, tx_start one cycle later with tx_data=8'hA5, busy falls one cycle after the done tick.
- All four valid with last=1 continuously -> grants served in order 0,1,2,3,0; exactly one tx_start per done tick.
- Req 1 sends 3-byte burst 8'h11, 8'h22, 8'h33 (last on third) while req 0 valid throughout -> transmitter sees 11, 22, 33 before any req 0 byte; req 0 is granted next.
- Req 3 sends one byte with last=0 then drops valid; LOCK_TIMEOUT=8 -> lock released after 8 LOAD cycles, busy=0 for one cycle, pending req 0 is then granted.
- reset_in pulsed low while in WAIT with tx_data=8'h5A -> tx_data=0, busy=0, grant_id=0 immediately; the next request from req 0 is granted first.
